registers_stage1: RTL and testbench
===================================

// Module: registers_stage1
// PURPOSE
//  Pipeline stage feeding registersstage2. Reads the register file, computes
//  effective addresses, issues the memory request for LOAD/STORE, detects RAW
//  hazards on registers still being written by stage 2, stalls fetch, and
//  registers the instruction forward as outbound_instruction.
// PARAMETERS
//  none
// PORTS
//  clock                 in   1   system clock
//  reset                 in   1   asynchronous, active-high
//  inbound_instruction   in   32  instruction from fetch; held by fetch while stall=1
//  reg_read_index_a      out  4   comb: inbound[19:16] (address register)
//  reg_read_index_b      out  4   comb: inbound[23:20] (store data register)
//  reg_read_data_a       in   32  register file async read port A
//  reg_read_data_b       in   32  register file async read port B
//  mem_address           out  30  registered longword address, ea[31:2]
//  mem_data_strobes      out  4   registered byte enables, [3]=bits 31:24
//  mem_read              out  1   registered read request
//  mem_write             out  1   registered write request
//  mem_data_out          out  32  registered store data, lane-replicated
//  bus_error             out  1   sticky misalignment flag
//  stall                 out  1   comb: hold fetch, bubble inserted
//  outbound_instruction  out  32  registered; to registersstage2.inbound_instruction
// BEHAVIOUR
//  Reset: outbound={OPCODE_NOP,27'h0}; mem_address=0; strobes=0; mem_read=0;
//   mem_write=0; mem_data_out=0; bus_error=0; scoreboard cleared.
//  Fields: [31:27] opcode, [26:25] t_cycle_width, [24] signed, [23:20] reg,
//   [19:16] address reg, [15:0] offset.
//  ea = reg_read_data_a + {{16{off[15]}},off}, 32-bit, wraps silently.
//  Latency 1: request and outbound update on the same edge. Memory returns
//   read data combinationally in that cycle; stage 2 latches it next edge.
//  Sources: LOAD -> [19:16]; STORE -> [19:16],[23:20]; all others none.
//   Dests: LOAD, LOADI -> [23:20].
//  Scoreboard: pend1 = dest of instruction now at stage2 input;
//   pend2 = dest being written by stage 2. Each entry is {valid,index}.
//   It shifts every edge; pend1 loads 0 on a bubble.
//  stall = any source matches a valid pend1/pend2. On stall:
//   outbound <= NOP, no request, fetch holds. Max 2 consecutive stall cycles.
//  Strobes (big-endian): BYTE 4'b1000>>ea[1:0]; WORD ea[1]?0011:1100; LONG 1111.
//  Store data: BYTE {4{b[7:0]}}, WORD {2{b[15:0]}}, LONG b.
//  Misaligned (WORD ea[0]=1, LONG ea[1:0]!=0): bus_error<=1, which persists
//   until reset. The access is squashed: outbound <= NOP, no strobes, no
//   read/write.
//  Non-memory opcodes: mem_read=mem_write=0, strobes=0; instruction passes.
//  mem_read/mem_write are single-cycle unless consecutive memory ops issue.
//  Reset mid-stall: the bubble is abandoned; the held instruction re-issues
//   after reset with the scoreboard empty.
// STRUCTURE
//  opcodes.vh: t_opcode, OPCODE_{NOP,LOAD,STORE,LOADI}, t_cycle_width
//   CW_{BYTE,WORD,LONG}, field position constants.
//  registers.vh: t_reg.
//  Sub-module byte_lane_encoder: combinational; width+ea[1:0]+data ->
//   strobes, replicated data, misaligned.
// TESTING
//  1 LOAD LONG r2,(r1+8), r1=0x1000 -> mem_address=0x402, strobes=1111,
//    mem_read=1 for 1 cycle, outbound=the LOAD.
//  2 STORE BYTE r3,(r1-1), r1=0x1000, r3=0xAB -> ea=0xFFF, strobes=0001,
//    data=0xABABABAB, mem_write=1.
//  3 LOAD r4,(r0); then LOAD r5,(r4) -> stall=1 for 2 cycles, two NOP
//    bubbles, then issue with the new r4.
//  4 LOADI r6; NOP; STORE r6,(r1) -> stall exactly 1 cycle.
//  5 LOAD WORD from ea=0x1001 -> bus_error=1, NOP forwarded, no strobes.
//    Following valid LOAD still issues; bus_error stays 1.
//  6 Assert reset during stall cycle 1 -> all outputs at reset values.
//    After release the held LOAD issues with stall=0.

Source files
------------

// File: rtl/registers_stage1_pkg.sv
// Shared instruction encoding for the register-read stage: opcodes, access widths, field positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package registers_stage1_pkg;

    typedef enum logic [4:0] {
        OPCODE_NOP   = 5'd0,
        OPCODE_LOAD  = 5'd1,
        OPCODE_STORE = 5'd2,
        OPCODE_LOADI = 5'd3
    } t_opcode;

    // Encoding 2'd3 is unassigned and is treated as a longword access.
    typedef enum logic [1:0] {
        CW_BYTE = 2'd0,
        CW_WORD = 2'd1,
        CW_LONG = 2'd2
    } t_cycle_width;

    typedef logic [3:0] t_reg;

    // One in-flight register write tracked by the hazard scoreboard.
    typedef struct packed {
        logic valid;
        t_reg index;
    } t_pend;

    // Instruction field positions.
    localparam int OPCODE_LSB = 27;
    localparam int CW_LSB     = 25;
    localparam int REG_LSB    = 20;
    localparam int AREG_LSB   = 16;

    localparam logic [31:0] NOP_INSTRUCTION = {OPCODE_NOP, 27'h0};

endpackage

// File: rtl/registers_stage1_byte_lane_encoder.sv
// Maps access width and low address bits to big-endian byte strobes and lane-replicated store data.
// Latency: combinational.
// Backpressure: none; flags misaligned WORD/LONG accesses for the caller to squash.
module registers_stage1_byte_lane_encoder
    import registers_stage1_pkg::*;
(
    input  t_cycle_width width,
    input  logic [1:0]   ea_low,
    input  logic [31:0]  data,
    output logic [3:0]   strobes,
    output logic [31:0]  lane_data,
    output logic         misaligned
);

    // Strobe bit 3 is the most significant byte lane (big-endian numbering).
    always_comb begin
        strobes    = 4'b1111;
        lane_data  = data;
        misaligned = 1'b0;
        case (width)
            CW_BYTE: begin
                strobes   = 4'b1000 >> ea_low;
                lane_data = {4{data[7:0]}};
            end
            CW_WORD: begin
                strobes    = ea_low[1] ? 4'b0011 : 4'b1100;
                lane_data  = {2{data[15:0]}};
                misaligned = ea_low[0];
            end
            default: begin
                strobes    = 4'b1111;
                lane_data  = data;
                misaligned = (ea_low != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/registers_stage1.sv
// Register-read stage: reads operands, forms the effective address, issues LOAD/STORE requests, tracks RAW hazards.
// Latency: 1 cycle; memory request and outbound instruction update on the same edge.
// Backpressure: stall holds fetch and inserts a NOP bubble while a source is still pending in stage 2.
module registers_stage1
    import registers_stage1_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inbound_instruction,
    output logic [3:0]  reg_read_index_a,
    output logic [3:0]  reg_read_index_b,
    input  logic [31:0] reg_read_data_a,
    input  logic [31:0] reg_read_data_b,
    output logic [29:0] mem_address,
    output logic [3:0]  mem_data_strobes,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_data_out,
    output logic        bus_error,
    output logic        stall,
    output logic [31:0] outbound_instruction
);

    t_opcode      opcode;
    t_cycle_width width;
    logic [31:0]  ea;
    logic         is_mem;
    logic         uses_b;
    logic         writes_dest;
    logic         hit_a;
    logic         hit_b;
    logic [3:0]   lane_strobes;
    logic [31:0]  lane_data;
    logic         misaligned;
    logic         issue_mem;
    logic         squash;
    t_pend        pend1;
    t_pend        pend2;

    assign opcode           = t_opcode'(inbound_instruction[OPCODE_LSB +: 5]);
    assign width            = t_cycle_width'(inbound_instruction[CW_LSB +: 2]);
    assign reg_read_index_a = inbound_instruction[AREG_LSB +: 4];
    assign reg_read_index_b = inbound_instruction[REG_LSB +: 4];

    // Address register is read by both memory ops; only STORE also reads the data register.
    assign is_mem      = (opcode == OPCODE_LOAD) || (opcode == OPCODE_STORE);
    assign uses_b      = (opcode == OPCODE_STORE);
    assign writes_dest = (opcode == OPCODE_LOAD) || (opcode == OPCODE_LOADI);

    assign ea = reg_read_data_a + {{16{inbound_instruction[15]}}, inbound_instruction[15:0]};

    assign hit_a = (pend1.valid && (pend1.index == reg_read_index_a)) ||
                   (pend2.valid && (pend2.index == reg_read_index_a));
    assign hit_b = (pend1.valid && (pend1.index == reg_read_index_b)) ||
                   (pend2.valid && (pend2.index == reg_read_index_b));

    assign stall = (is_mem && hit_a) || (uses_b && hit_b);

    registers_stage1_byte_lane_encoder u_lane (
        .width      (width),
        .ea_low     (ea[1:0]),
        .data       (reg_read_data_b),
        .strobes    (lane_strobes),
        .lane_data  (lane_data),
        .misaligned (misaligned)
    );

    // A misaligned access that would otherwise issue is dropped and replaced by a bubble.
    assign squash    = is_mem && !stall && misaligned;
    assign issue_mem = is_mem && !stall && !misaligned;

    // Pipeline register, memory request and hazard scoreboard advance together every edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outbound_instruction <= NOP_INSTRUCTION;
            mem_address          <= '0;
            mem_data_strobes     <= '0;
            mem_read             <= 1'b0;
            mem_write            <= 1'b0;
            mem_data_out         <= '0;
            bus_error            <= 1'b0;
            pend1                <= '0;
            pend2                <= '0;
        end else begin
            pend2       <= pend1;
            pend1.valid <= writes_dest && !stall && !squash;
            pend1.index <= reg_read_index_b;

            mem_read         <= issue_mem && (opcode == OPCODE_LOAD);
            mem_write        <= issue_mem && (opcode == OPCODE_STORE);
            mem_data_strobes <= issue_mem ? lane_strobes : 4'b0000;
            if (issue_mem) begin
                mem_address  <= ea[31:2];
                mem_data_out <= lane_data;
            end

            if (squash) begin
                bus_error <= 1'b1;
            end

            outbound_instruction <= (stall || squash) ? NOP_INSTRUCTION : inbound_instruction;
        end
    end

endmodule

// File: tb/tb_registers_stage1.sv
// Bench for registers_stage1: directed instruction vectors against a behavioural readiness model.
// Latency: expects registered outputs one edge after an instruction is presented.
// Backpressure: the bench acts as fetch and re-presents an instruction for each expected stall cycle.
module tb_registers_stage1;
    import registers_stage1_pkg::*;

    logic        clock = 1'b1;
    logic        reset = 1'b1;
    logic [31:0] inbound = 32'h0;
    logic [3:0]  idx_a, idx_b;
    logic [31:0] rda, rdb;
    logic [29:0] mem_address;
    logic [3:0]  strobes;
    logic        mem_read, mem_write;
    logic [31:0] mem_data_out;
    logic        bus_error, stall;
    logic [31:0] outbound;
    logic [31:0] regs [16];

    int checks = 0;
    int errors = 0;

    assign rda = regs[idx_a];
    assign rdb = regs[idx_b];

    registers_stage1 dut (
        .clock                (clock),
        .reset                (reset),
        .inbound_instruction  (inbound),
        .reg_read_index_a     (idx_a),
        .reg_read_index_b     (idx_b),
        .reg_read_data_a      (rda),
        .reg_read_data_b      (rdb),
        .mem_address          (mem_address),
        .mem_data_strobes     (strobes),
        .mem_read             (mem_read),
        .mem_write            (mem_write),
        .mem_data_out         (mem_data_out),
        .bus_error            (bus_error),
        .stall                (stall),
        .outbound_instruction (outbound)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] cw,
                                       input logic [3:0] r, input logic [3:0] a,
                                       input logic [15:0] off);
        return {op, cw, 1'b0, r, a, off};
    endfunction

    // ---------------- behavioural model ----------------
    // A register written by a LOAD/LOADI issued in cycle t may be read from cycle t+3 on.
    int          ready [16];
    int          cyc = 0;
    logic        berr_m = 1'b0;
    logic [31:0] exp_out = 32'h0;
    logic        exp_rd = 1'b0, exp_wr = 1'b0;
    logic [3:0]  exp_strb = 4'h0;
    logic [29:0] exp_addr = '0;
    logic [31:0] exp_data = 32'h0;

    // Compare process: checks registered outputs against the previous prediction, then predicts the next edge.
    always @(negedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) ready[i] = 0;
            berr_m = 1'b0; exp_out = 32'h0; exp_rd = 1'b0; exp_wr = 1'b0;
            exp_strb = 4'h0; exp_addr = '0; exp_data = 32'h0;
            if (!clock) begin
                chk("rst_outbound", outbound, 32'h0);
                chk("rst_addr", {2'b0, mem_address}, 32'h0);
                chk("rst_strobes", {28'h0, strobes}, 32'h0);
                chk("rst_read", {31'h0, mem_read}, 32'h0);
                chk("rst_write", {31'h0, mem_write}, 32'h0);
                chk("rst_data", mem_data_out, 32'h0);
                chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
                chk("rst_stall", {31'h0, stall}, 32'h0);
            end
        end else begin
            logic [4:0]  op;
            logic [1:0]  cw;
            logic [3:0]  rb, ra;
            logic [31:0] ea, v;
            int          lo;
            logic        need_a, need_b, st, mis;

            chk("outbound", outbound, exp_out);
            chk("mem_read", {31'h0, mem_read}, {31'h0, exp_rd});
            chk("mem_write", {31'h0, mem_write}, {31'h0, exp_wr});
            chk("strobes", {28'h0, strobes}, {28'h0, exp_strb});
            chk("bus_error", {31'h0, bus_error}, {31'h0, berr_m});
            if (exp_rd || exp_wr) chk("mem_address", {2'b0, mem_address}, {2'b0, exp_addr});
            if (exp_wr) chk("mem_data", mem_data_out, exp_data);

            op = inbound[31:27]; cw = inbound[26:25]; rb = inbound[23:20]; ra = inbound[19:16];
            need_a = (op == 5'd1) || (op == 5'd2);
            need_b = (op == 5'd2);
            st = (need_a && ready[ra] > cyc) || (need_b && ready[rb] > cyc);
            chk("stall", {31'h0, stall}, {31'h0, st});

            exp_rd = 1'b0; exp_wr = 1'b0; exp_strb = 4'h0; mis = 1'b0;
            exp_out = st ? 32'h0 : inbound;
            if (!st && need_a) begin
                ea = regs[ra] + {{16{inbound[15]}}, inbound[15:0]};
                lo = int'(ea % 4);
                v  = regs[rb];
                if (cw == 2'd0) begin
                    exp_strb = 4'(1 << (3 - lo));
                    exp_data = {v[7:0], v[7:0], v[7:0], v[7:0]};
                end else if (cw == 2'd1) begin
                    mis = (lo % 2) != 0;
                    exp_strb = (lo < 2) ? 4'b1100 : 4'b0011;
                    exp_data = {v[15:0], v[15:0]};
                end else begin
                    mis = (lo != 0);
                    exp_strb = 4'b1111;
                    exp_data = v;
                end
                if (mis) begin
                    berr_m = 1'b1; exp_out = 32'h0; exp_strb = 4'h0;
                end else begin
                    exp_addr = 30'(ea / 4);
                    if (op == 5'd1) exp_rd = 1'b1; else exp_wr = 1'b1;
                end
            end
            if (!st && !mis && (op == 5'd1 || op == 5'd3)) ready[rb] = cyc + 3;
        end
        if (!clock) cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic [31:0] ins);
        @(posedge clock);
        #2 inbound = ins;
        #1;
    endtask

    logic [31:0] ld1, st2, l4, l5, li6, st6, lw7, ll8;

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'h0;
        regs[1] = 32'h0000_1000;
        regs[3] = 32'h0000_00AB;
        regs[6] = 32'hCAFE_F00D;
        ld1 = mk(5'd1, 2'd2, 4'd2, 4'd1, 16'h0008);
        st2 = mk(5'd2, 2'd0, 4'd3, 4'd1, 16'hFFFF);
        l4  = mk(5'd1, 2'd2, 4'd4, 4'd0, 16'h0000);
        l5  = mk(5'd1, 2'd2, 4'd5, 4'd4, 16'h0000);
        li6 = mk(5'd3, 2'd0, 4'd6, 4'd0, 16'h0055);
        st6 = mk(5'd2, 2'd2, 4'd6, 4'd1, 16'h0000);
        lw7 = mk(5'd1, 2'd1, 4'd7, 4'd1, 16'h0001);
        ll8 = mk(5'd1, 2'd2, 4'd8, 4'd1, 16'h0004);

        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;

        // LOAD LONG r2,(r1+8): longword 0x402, all lanes, one-cycle read
        issue(ld1);
        issue(32'h0);
        chk("t1_addr", {2'b0, mem_address}, 32'h402);
        chk("t1_strobes", {28'h0, strobes}, 32'hF);
        chk("t1_read", {31'h0, mem_read}, 32'h1);
        chk("t1_outbound", outbound, ld1);

        // STORE BYTE r3,(r1-1): ea 0xFFF, lowest lane, replicated byte
        issue(st2);
        chk("t1_read_drops", {31'h0, mem_read}, 32'h0);
        issue(32'h0);
        chk("t2_addr", {2'b0, mem_address}, 32'h3FF);
        chk("t2_strobes", {28'h0, strobes}, 32'h1);
        chk("t2_data", mem_data_out, 32'hABAB_ABAB);
        chk("t2_write", {31'h0, mem_write}, 32'h1);

        // LOAD r4,(r0) then LOAD r5,(r4): two bubbles, then issue with the new r4
        issue(l4);
        issue(l5);
        chk("t3_stall1", {31'h0, stall}, 32'h1);
        issue(l5);
        chk("t3_stall2", {31'h0, stall}, 32'h1);
        chk("t3_bubble", outbound, 32'h0);
        regs[4] = 32'h0000_3000;
        issue(l5);
        chk("t3_go", {31'h0, stall}, 32'h0);
        issue(32'h0);
        chk("t3_addr", {2'b0, mem_address}, 32'hC00);
        chk("t3_outbound", outbound, l5);

        // LOADI r6; NOP; STORE r6,(r1): exactly one stall cycle
        issue(li6);
        issue(32'h0);
        issue(st6);
        chk("t4_stall", {31'h0, stall}, 32'h1);
        issue(st6);
        chk("t4_go", {31'h0, stall}, 32'h0);
        issue(32'h0);
        chk("t4_write", {31'h0, mem_write}, 32'h1);
        chk("t4_data", mem_data_out, 32'hCAFE_F00D);
        chk("t4_addr", {2'b0, mem_address}, 32'h400);

        // LOAD WORD at 0x1001: squashed, sticky bus_error; next LOAD still issues
        issue(lw7);
        issue(ll8);
        chk("t5_bus_error", {31'h0, bus_error}, 32'h1);
        chk("t5_outbound", outbound, 32'h0);
        chk("t5_strobes", {28'h0, strobes}, 32'h0);
        chk("t5_read", {31'h0, mem_read}, 32'h0);
        issue(32'h0);
        chk("t5_next_read", {31'h0, mem_read}, 32'h1);
        chk("t5_next_addr", {2'b0, mem_address}, 32'h401);
        chk("t5_sticky", {31'h0, bus_error}, 32'h1);

        // Reset in the first stall cycle: bubble abandoned, held LOAD re-issues
        issue(l4);
        issue(l5);
        chk("t6_stall", {31'h0, stall}, 32'h1);
        reset = 1'b1;
        #1;
        chk("t6_rst_outbound", outbound, 32'h0);
        chk("t6_rst_bus_error", {31'h0, bus_error}, 32'h0);
        chk("t6_rst_stall", {31'h0, stall}, 32'h0);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("t6_nostall", {31'h0, stall}, 32'h0);
        issue(32'h0);
        chk("t6_read", {31'h0, mem_read}, 32'h1);
        chk("t6_addr", {2'b0, mem_address}, 32'hC00);
        chk("t6_outbound", outbound, l5);

        issue(32'h0);
        issue(32'h0);
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
